// File: rtl/n4_b2_sorter4_pkg.sv
// Shared definitions for the four-element sequential sorter: FSM encoding,
// element geometry and the fixed bubble-sort pair schedule.
package n4_b2_sorter4_pkg;

    localparam int ELEM_W = 4;
    localparam int ELEM_N = 4;
    localparam logic [2:0] LAST_STEP = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] lo;
        logic [1:0] hi;
    } pair_t;

    // Six compare-exchange steps of a 4-element bubble sort.
    function automatic pair_t pair_sel(input logic [2:0] step);
        pair_t p;
        case (step)
            3'd0:    p = '{lo: 2'd0, hi: 2'd1};
            3'd1:    p = '{lo: 2'd1, hi: 2'd2};
            3'd2:    p = '{lo: 2'd2, hi: 2'd3};
            3'd3:    p = '{lo: 2'd0, hi: 2'd1};
            3'd4:    p = '{lo: 2'd1, hi: 2'd2};
            default: p = '{lo: 2'd0, hi: 2'd1};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/n4_b2_integer_comparator.sv
// Signed 4-bit comparator; operands are sign-extended to 5 bits so the
// difference of any two 4-bit values cannot overflow.
module n4_b2_integer_comparator (
    input  logic [3:0] x3_x0,
    input  logic [3:0] y3_y0,
    output logic       flag_gr,
    output logic       flag_eq,
    output logic       flag_lr
);
    logic [4:0] diff;

    n5_b2_subtractor u_sub (
        .a    ({x3_x0[3], x3_x0}),
        .b    ({y3_y0[3], y3_y0}),
        .diff (diff)
    );

    assign flag_eq = (diff == 5'd0);
    assign flag_lr = diff[4];
    assign flag_gr = !diff[4] && (diff != 5'd0);
endmodule

// File: rtl/n5_b2_subtractor.sv
// 5-bit two's-complement subtractor: diff = a - b, wrapping.
module n5_b2_subtractor (
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic [4:0] diff
);
    logic signed [4:0] a_s;
    logic signed [4:0] b_s;

    assign a_s  = a;
    assign b_s  = b;
    assign diff = a_s - b_s;
endmodule

// File: rtl/n4_b2_sorter4.sv
// Sequential sorter for four signed 4-bit values: one shared comparator walks
// a fixed six-step bubble-sort schedule, one compare-exchange per cycle.
module n4_b2_sorter4
    import n4_b2_sorter4_pkg::*;
#(
    parameter bit DESCENDING = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic [2:0]  swaps,
    output logic        busy,
    output logic        done
);
    state_t      state_q;
    logic [2:0]  step_q;
    logic [2:0]  swap_cnt_q;
    logic [3:0]  r_q [ELEM_N];
    logic [3:0]  r_d [ELEM_N];
    logic [15:0] data_out_q;
    logic [2:0]  swaps_q;
    logic        busy_q;
    logic        done_q;

    pair_t      pair;
    logic [3:0] x_op;
    logic [3:0] y_op;
    logic       flag_gr;
    logic       flag_eq;
    logic       flag_lr;
    logic       swap;
    logic [2:0] swap_cnt_d;

    assign pair = pair_sel(step_q);
    assign x_op = r_q[pair.lo];
    assign y_op = r_q[pair.hi];

    n4_b2_integer_comparator u_cmp (
        .x3_x0   (x_op),
        .y3_y0   (y_op),
        .flag_gr (flag_gr),
        .flag_eq (flag_eq),
        .flag_lr (flag_lr)
    );

    // Equal pairs never exchange, which keeps the sort stable.
    assign swap       = (state_q == ST_SORT) && !flag_eq && (DESCENDING ? flag_lr : flag_gr);
    assign swap_cnt_d = swap_cnt_q + {2'b00, swap};

    always_comb begin
        r_d = r_q;
        if (swap) begin
            r_d[pair.lo] = y_op;
            r_d[pair.hi] = x_op;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            step_q     <= 3'd0;
            swap_cnt_q <= 3'd0;
            for (int i = 0; i < ELEM_N; i++) r_q[i] <= 4'd0;
            data_out_q <= 16'h0000;
            swaps_q    <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_SORT: begin
                    r_q        <= r_d;
                    swap_cnt_q <= swap_cnt_d;
                    step_q     <= step_q + 3'd1;
                    if (step_q == LAST_STEP) begin
                        data_out_q <= {r_d[3], r_d[2], r_d[1], r_d[0]};
                        swaps_q    <= swap_cnt_d;
                        state_q    <= ST_DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        for (int i = 0; i < ELEM_N; i++) r_q[i] <= data_in[i*ELEM_W +: ELEM_W];
                        step_q     <= 3'd0;
                        swap_cnt_q <= 3'd0;
                        state_q    <= ST_SORT;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                    end
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign data_out = data_out_q;
    assign swaps    = swaps_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: doc/n4_b2_sorter4.md
# n4_b2_sorter4

Sequential sorter for four 4-bit two's-complement integers. It time-shares a single `n4_b2_integer_comparator` across a fixed six-step bubble-sort schedule. A controller FSM selects which pair to compare, swaps the pair on the comparator flags, and counts swaps. It sits next to the subtractor/comparator datapath as its first sequencing client.

## Interface
- `DESCENDING`, default 0: 0 sorts ascending (swap when `flag_gr`); 1 sorts descending (swap when `flag_lr`).
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high; forces the reset state immediately.
- `start`  in  1  request a sort; sampled on a rising edge only while `busy`=0.
- `data_in`  in  16  four operands; element i = `data_in[4i+3:4i]`, two's complement.
- `data_out`  out  16  sorted result, same packing; element 0 is the first in sort order.
- `swaps`  out  3  number of swaps performed by the last sort, 0..6.
- `busy`  out  1  high while sorting.
- `done`  out  1  one-cycle pulse when `data_out`/`swaps` are updated.

## Operation
- States: IDLE, SORT, DONE.
- IDLE or DONE with `start`=1:
  - capture `data_in` into working registers r0..r3;
  - clear the step counter (0..5) and the swap counter;
  - go to SORT.
- SORT performs one step per cycle. Fixed pair schedule by step: (r0,r1), (r1,r2), (r2,r3), (r0,r1), (r1,r2), (r0,r1).
- Pair selection is a combinational mux feeding the comparator (`x3_x0` = lower-index element, `y3_y0` = higher-index element).
- At each edge in SORT:
  - if the swap condition holds, exchange the pair and increment the swap counter;
  - advance the step counter.
- Equal values are never swapped, so the sort is stable and `flag_eq` causes no action.
- On the edge that completes step 5:
  - load `data_out` from the final r0..r3, including the swap of that step;
  - load `swaps`;
  - go to DONE.
- DONE lasts one cycle, then IDLE unless `start`=1.
- `start` while in SORT is ignored. It is neither queued nor restarting.
- `data_in` is only sampled at capture, so changes during SORT have no effect.
- Signed correctness relies on the comparator's 5-bit sign extension. Extreme pairs such as 7 vs −8 must order correctly.
- Reset:
  - state = IDLE; r0..r3 = 0;
  - `data_out` = 16'h0000, `swaps` = 0, `busy` = 0, `done` = 0.
- A reset asserted mid-sort abandons the sort. `data_out` is cleared, not left holding partial data.

## Timing
- Outputs are registered. `busy` = (state == SORT); `done` = (state == DONE).
- Capture edge E0: `busy` rises after E0.
- Steps execute at E1..E6. After E6, `busy`=0, `done`=1, and `data_out`/`swaps` are valid.
- After E7, `done`=0 while `data_out`/`swaps` hold until the next completion or reset.
- Latency: 6 cycles from the capture edge to valid result.
- Back-to-back throughput: one sort every 7 cycles. `start` held high in DONE recaptures at E7.
- `data_out` never shows intermediate working-register contents.

## Structure
- Shared package holds:
  - state encoding constants (IDLE, SORT, DONE);
  - the 6-entry pair-schedule table (step → lower index, upper index);
  - the element width (4) and element count (4).
- One sub-module instance: `n4_b2_integer_comparator`, which internally instantiates `n5_b2_subtractor`. No other sub-modules. The mux, swap logic and FSM stay in this block.

## Test plan
- Mixed signs: `data_in`=16'h87E3 (3,−2,7,−8) → after 6 cycles `done` pulses, `data_out`=16'h73E8 (−8,−2,3,7), `swaps`=4.
- Already sorted: `data_in`=16'h7310 → `data_out`=16'h7310, `swaps`=0.
- Reverse order: `data_in`=16'hF137 (7,3,1,−1) → `data_out`=16'h731F, `swaps`=6.
- Extremes and duplicates: `data_in`=16'h7878 (−8,7,−8,7) → `data_out`=16'h7788, `swaps`=1.
  - Check that the 7 vs 7 pair is not swapped.
  - Check that 7 vs −8 orders without overflow.
- Control:
  - pulse `start` again at cycle 3 of SORT with different data → ignored, result is from the first capture;
  - hold `start` through DONE → second sort captured at E7.
- Reset mid-sort: assert `reset` asynchronously at step 3 → outputs immediately 0, state IDLE; the next `start` completes a normal sort.
- With `DESCENDING`=1: `data_in`=16'h87E3 → `data_out`=16'h8E37.
